// File: rtl/cp0_interrupt_unit.sv
// Coprocessor-0 for the 5-stage MIPS pipeline: status/cause/EPC/handler-base registers,
// external interrupt synchronisation and latching, and PC redirect on interrupt entry or ERET.
module cp0_interrupt_unit #(
    parameter logic [31:0] HANDLER_RST = 32'h0000_0008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  oper,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic [31:0] ret_addr,
    input  logic        ret_valid,
    input  logic        ir_en,
    input  logic        ir_in,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        in_service
);

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_STORE = 2'd1,
        OP_ERET  = 2'd2,
        OP_RSVD  = 2'd3
    } cp_oper_e;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_EHBR  = 5'd15;

    cp_oper_e op;
    assign op = cp_oper_e'(oper);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_hist_q;
    logic                   sync_out;
    logic                   ir_edge;

    logic        sr_ie_q;
    logic [31:0] epc_q;
    logic [31:0] ehbr_q;
    logic        pending_q;
    logic        in_service_q;

    logic        op_none;
    logic        do_store;
    logic        do_eret;
    logic        do_take;

    // Synchroniser and edge history run regardless of en so that no edge is lost while stalled.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            edge_hist_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ir_in};
            edge_hist_q <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign ir_edge  = sync_out & ~edge_hist_q;

    assign op_none  = (op == OP_NONE) || (op == OP_RSVD);
    assign do_store = en && (op == OP_STORE);
    assign do_eret  = en && (op == OP_ERET);
    assign do_take  = en && pending_q && sr_ie_q && ir_en && !in_service_q && ret_valid && op_none;

    // A fresh edge wins over the clear on take, so an interrupt arriving during entry stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (ir_edge) begin
            pending_q <= 1'b1;
        end else if (do_take) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_service_q <= 1'b0;
        end else if (do_take) begin
            in_service_q <= 1'b1;
        end else if (do_eret) begin
            in_service_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_ie_q <= 1'b0;
            epc_q   <= '0;
            ehbr_q  <= HANDLER_RST;
        end else begin
            if (do_store && addr_w == ADDR_SR) begin
                sr_ie_q <= data_w[0];
            end
            if (do_take) begin
                epc_q <= ret_addr;
            end else if (do_store && addr_w == ADDR_EPC) begin
                epc_q <= data_w;
            end
            if (do_store && addr_w == ADDR_EHBR) begin
                ehbr_q <= {data_w[31:2], 2'b00};
            end
        end
    end

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        jump_en   = 1'b0;
        jump_addr = '0;
        if (do_take) begin
            jump_en   = 1'b1;
            jump_addr = ehbr_q;
        end else if (do_eret) begin
            jump_en   = 1'b1;
            jump_addr = epc_q;
        end
    end

    // CAUSE is read-only, so a store aimed at it has nothing to forward.
    always_comb begin
        data_r = '0;
        unique case (addr_r)
            ADDR_SR:    data_r = {31'b0, sr_ie_q};
            ADDR_CAUSE: data_r = {in_service_q, 20'b0, pending_q, 10'b0};
            ADDR_EPC:   data_r = epc_q;
            ADDR_EHBR:  data_r = ehbr_q;
            default:    data_r = '0;
        endcase
        if (do_store && addr_w == addr_r) begin
            unique case (addr_w)
                ADDR_SR:   data_r = {31'b0, data_w[0]};
                ADDR_EPC:  data_r = data_w;
                ADDR_EHBR: data_r = {data_w[31:2], 2'b00};
                default:   ;
            endcase
        end
    end

    assign in_service = in_service_q;

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Scoreboard bench for cp0_interrupt_unit: directed test-plan scenarios followed by random
// traffic, checked against a register-level reference model of CP0 behaviour.
module tb_cp0_interrupt_unit;

    localparam int          SYNC = 2;
    localparam logic [31:0] HRST = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  oper = 2'd0;
    logic [4:0]  addr_r = 5'd0;
    logic [31:0] data_r;
    logic [4:0]  addr_w = 5'd0;
    logic [31:0] data_w = '0;
    logic [31:0] ret_addr = '0;
    logic        ret_valid = 1'b0;
    logic        ir_en = 1'b0;
    logic        ir_in = 1'b0;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        in_service;

    always #5 clk = ~clk;

    cp0_interrupt_unit #(.HANDLER_RST(HRST), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .en(en), .oper(oper),
        .addr_r(addr_r), .data_r(data_r), .addr_w(addr_w), .data_w(data_w),
        .ret_addr(ret_addr), .ret_valid(ret_valid), .ir_en(ir_en), .ir_in(ir_in),
        .jump_en(jump_en), .jump_addr(jump_addr), .in_service(in_service)
    );

    typedef struct {
        logic        je;
        logic [31:0] ja;
        logic [31:0] dr;
        logic        isv;
        int          cyc;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;

    // Reference model: architectural registers plus a history of sampled ir_in levels.
    logic        m_ie, m_pend, m_isv;
    logic [31:0] m_epc, m_ehbr;
    logic        hist[$];

    task automatic model_reset();
        m_ie = 1'b0; m_pend = 1'b0; m_isv = 1'b0; m_epc = '0; m_ehbr = HRST;
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {31'b0, m_ie};
            5'd13:   return {m_isv, 20'b0, m_pend, 10'b0};
            5'd14:   return m_epc;
            5'd15:   return m_ehbr;
            default: return 32'h0;
        endcase
    endfunction

    // One cycle: predict outputs from the model, queue them, then advance the model at the edge.
    task automatic tick(input string tag);
        exp_t e;
        logic take, eret, store, edge_seen;
        store = en && oper == 2'd1;
        eret  = en && oper == 2'd2;
        take  = en && m_pend && m_ie && ir_en && !m_isv && ret_valid && (oper == 2'd0 || oper == 2'd3);
        e.je  = take || eret;
        e.ja  = take ? m_ehbr : (eret ? m_epc : 32'h0);
        e.dr  = m_read(addr_r);
        if (store && addr_w == addr_r) begin
            if (addr_r == 5'd12) e.dr = {31'b0, data_w[0]};
            if (addr_r == 5'd14) e.dr = data_w;
            if (addr_r == 5'd15) e.dr = data_w & 32'hFFFF_FFFC;
        end
        e.isv = m_isv;
        e.cyc = cyc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        // Edge seen now: level sampled SYNC edges ago is 1, the one before it was 0.
        edge_seen = hist[hist.size() - SYNC] && !hist[hist.size() - SYNC - 1];
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back(ir_in);
            if (hist.size() > 8) void'(hist.pop_front());
            if (edge_seen) m_pend = 1'b1;
            else if (take) m_pend = 1'b0;
            if (take) begin m_epc = ret_addr; m_isv = 1'b1; end
            if (eret) m_isv = 1'b0;
            if (store && addr_w == 5'd12) m_ie = data_w[0];
            if (store && addr_w == 5'd14) m_epc = data_w;
            if (store && addr_w == 5'd15) m_ehbr = data_w & 32'hFFFF_FFFC;
        end
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v, input int c);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, c, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".jump_en"},    {31'b0, jump_en},    {31'b0, e.je},  e.cyc);
            check({t, ".jump_addr"},  jump_addr,           e.ja,           e.cyc);
            check({t, ".data_r"},     data_r,              e.dr,           e.cyc);
            check({t, ".in_service"}, {31'b0, in_service}, {31'b0, e.isv}, e.cyc);
        end
    end

    task automatic store(input logic [4:0] a, input logic [31:0] d, input string tag);
        oper = 2'd1; addr_w = a; data_w = d; addr_r = a;
        tick(tag);
        oper = 2'd0;
    endtask

    task automatic make_edge(input string tag);
        ir_in = 1'b0; ticks(2, tag);
        ir_in = 1'b1; ticks(SYNC + 2, tag);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;

        // Reset and register readback
        rst = 1'b1; ticks(2, "reset");
        rst = 1'b0;
        for (int a = 12; a <= 16; a++) begin
            addr_r = 5'(a); tick("rst_read");
        end

        // First interrupt entry
        store(5'd12, 32'hFFFF_FFFF, "sr_wr");
        store(5'd15, 32'h0000_0103, "ehbr_wr");
        ret_addr = 32'h40; ret_valid = 1'b1; ir_en = 1'b1; addr_r = 5'd13;
        ir_in = 1'b1; ticks(5, "take1");
        addr_r = 5'd14; tick("epc_rd");

        // Second edge while in service, ERET, then the held interrupt is taken
        addr_r = 5'd13; make_edge("nest");
        oper = 2'd2; tick("eret1");
        oper = 2'd0; tick("take2");
        oper = 2'd2; tick("eret2");
        oper = 2'd0;

        // Each blocker holds off the take until it is removed
        for (int b = 0; b < 3; b++) begin
            if (b == 0) ir_en = 1'b0;
            if (b == 1) ret_valid = 1'b0;
            if (b == 2) en = 1'b0;
            make_edge("blocked");
            ticks(2, "blocked");
            ir_en = 1'b1; ret_valid = 1'b1; en = 1'b1;
            tick("unblock_take");
            oper = 2'd2; tick("eret_b"); oper = 2'd0;
        end

        // STORE to EPC in the same cycle as a ready take
        ir_en = 1'b0; make_edge("pend_hold");
        ir_en = 1'b1; ret_addr = 32'h0000_0200;
        store(5'd14, 32'h0000_0ABC, "store_blocks");
        addr_r = 5'd14; tick("take_after_store");
        tick("epc_after_take");

        // Reset while in service with a pending interrupt, ir_in left high
        addr_r = 5'd13; make_edge("pend_in_svc");
        rst = 1'b1; tick("mid_rst");
        rst = 1'b0; ticks(6, "post_rst");
        addr_r = 5'd14; tick("post_rst_epc");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst       = ($urandom_range(0, 99) < 2);
            en        = ($urandom_range(0, 99) < 85);
            r         = $urandom_range(0, 9);
            oper      = (r < 6) ? 2'd0 : (r < 7) ? 2'd3 : (r < 8) ? 2'd1 : 2'd2;
            addr_r    = ($urandom_range(0, 9) < 8) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
            addr_w    = ($urandom_range(0, 9) < 8) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
            data_w    = $urandom;
            ret_addr  = $urandom;
            ret_valid = ($urandom_range(0, 9) < 8);
            ir_en     = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) ir_in = ~ir_in;
            tick("random");
        end

        rst = 1'b0; en = 1'b1; oper = 2'd0;
        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_interrupt_unit.md
Name: cp0_interrupt_unit

Overview:
- Coprocessor-0 block for the 5-stage pipelined MIPS CPU, sitting beside the EXE stage.
- Consumes the decoder's cp_oper (NONE/STORE/ERET), the register write data, and the PC of the instruction to resume.
- Holds the status, cause, EPC and handler-base registers, and synchronises and latches one external interrupt line.
- Produces jump_en/jump_addr, which redirect the PC and flush the ID stage on interrupt entry or ERET.

Parameters:
HANDLER_RST, 32'h0000_0008, reset value of handler-base register EHBR
SYNC_STAGES, 2, flops in external-interrupt synchroniser (>=2)

Ports:
clk  in  1  main clock
rst  in  1  reset
en  in  1  stage enable; 0 freezes all state and forces jump_en=0
oper  in  2  0=NONE, 1=STORE (mtc0), 2=ERET, 3=reserved (treated as NONE)
addr_r  in  5  CP0 read address (mfc0)
data_r  out  32  CP0 read data, combinational
addr_w  in  5  CP0 write address (mtc0)
data_w  in  32  CP0 write data
ret_addr  in  32  PC to resume at when an interrupt is taken
ret_valid  in  1  ret_addr belongs to a valid, non-bubble instruction
ir_en  in  1  global interrupt permit from controller
ir_in  in  1  external interrupt, asynchronous, rising-edge meaningful
jump_en  out  1  redirect PC this cycle (combinational)
jump_addr  out  32  redirect target; 0 when jump_en=0
in_service  out  1  handler currently active

Behaviour:
- Reset is synchronous and active-high: rst is sampled on the rising edge of clk; the clock is clk.
- Register map:
  - 12 SR: bit0 = IE, other bits read 0, write-masked.
  - 13 CAUSE: read-only; bit10 = pending, bit31 = in_service, rest 0.
  - 14 EPC: 32-bit, RW.
  - 15 EHBR: 32-bit, RW, bits[1:0] forced 0.
  - Other addresses read 0; writes to them are ignored.
- Reset values: SR=0, CAUSE fields=0, EPC=0, EHBR=HANDLER_RST, synchroniser flops=0, edge-history=0, pending=0, in_service=0. Outputs after reset: jump_en=0, jump_addr=0.
- Interrupt input path:
  - ir_in passes through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge sets pending on the next clock.
  - pending stays set until the interrupt is taken.
  - Further edges while pending are absorbed (no counting).
  - Edge detection runs even when en=0, so no edge is lost.
- take condition (combinational): en & pending & SR.IE & ir_en & ~in_service & ret_valid & (oper==NONE).
- take cycle:
  - jump_en=1, jump_addr=EHBR.
  - At the clock edge: EPC<=ret_addr, in_service<=1, pending<=0.
  - If a new edge arrives in the same cycle, pending stays 1.
- ERET (en & oper==2):
  - jump_en=1, jump_addr=EPC (the value before this edge).
  - At the clock edge: in_service<=0.
  - ERET while in_service=0 still jumps to EPC.
- STORE (en & oper==1): the addressed register updates at the clock edge.
- Priority:
  - ERET and STORE block take for that cycle; pending is retained and the interrupt is taken at the earliest later cycle meeting the take condition.
  - Nesting is impossible: take requires ~in_service.
- Read bypass: if en & oper==1 & addr_w==addr_r and the address is implemented, data_r returns the masked data_w. Otherwise data_r returns the current register value.
- en=0: no register, pending-clear or in_service change; jump_en=0.
- rst mid-handler: in_service and pending clear, EPC=0, SR.IE=0; an interrupt already in flight is dropped.
- Latency: ir_in rising edge → pending set after SYNC_STAGES+1 clocks; jump_en at the first cycle after that meeting the take condition.

Test Plan:
- Reset, then read addresses 12/13/14/15 → 0, 0, 0, 32'h8; jump_en=0.
- mtc0 SR=1, EHBR=32'h100; ir_in 0→1 held; ret_addr=32'h40, ret_valid=1 → pending after 3 clocks; next cycle jump_en=1, jump_addr=32'h100; EPC then reads 32'h40, CAUSE bit31=1.
- Second ir_in edge while in_service → no jump; CAUSE bit10=1. ERET → jump_en=1, jump_addr=32'h40; next cycle the pending interrupt is taken (jump_addr=32'h100).
- pending with SR.IE=1 but ir_en=0 (or ret_valid=0, or en=0) → jump_en stays 0; deasserting the blocker → take in that same cycle.
- Same cycle: pending ready and oper=STORE to EPC with 32'hABC → store applied, no take; take next cycle overwrites EPC with ret_addr.
- rst asserted while in_service=1 with pending=1 → next cycle all state at reset values; ir_in still high gives no new take without a fresh rising edge.
